uart_tx_mmio: RTL and testbench
===============================

Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter sitting directly downstream of the CPU data path; it consumes store traffic (MemWrite, ALU address, rs2 data).
- Stores to the TX data address queue a byte in a small FIFO, and the serialiser shifts it out 8N1, LSB first.
- A status word is readable by the CPU load path, so software can poll before writing.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); must be >= 2.
- FIFO_DEPTH, 8, TX byte FIFO entries; power of two, >= 2.
- TX_ADDR, 32'h0000_0400, byte address of the TX data register (write-only).
- STAT_ADDR, 32'h0000_0404, byte address of the status register.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- mem_write  in  1  CPU store strobe, single cycle per store
- address  in  32  CPU store/load address (ALU result)
- write_data  in  32  CPU store data (rs2); bits [7:0] used
- read_data  out  32  status word, combinational; 0 when address != STAT_ADDR
- tx  out  1  serial line, registered, idle high
- tx_busy  out  1  high while the serialiser is not in IDLE

Behaviour:
- Reset (async, active-high) forces the following, all asserted immediately and held while reset is high:
  - tx=1, tx_busy=0, FSM=IDLE
  - FIFO empty (pointers and count = 0), overflow=0, baud counter=0, bit index=0
- Reset mid-frame aborts the frame; tx returns to 1 at once.
- Push: on a rising edge with mem_write=1 and address==TX_ADDR, write_data[7:0] enters the FIFO.
  - If the FIFO is full and no pop occurs that cycle, the byte is dropped and overflow is set (sticky).
  - If full with a simultaneous pop, the push is accepted and the count is unchanged.
- Overflow clear: a store to STAT_ADDR with write_data[2]=1 clears overflow. Stores to other addresses are ignored.
- Status word, read_data when address==STAT_ADDR:
  - [0] fifo_full
  - [1] fifo_empty
  - [2] overflow
  - [3] tx_busy
  - [7:4] 0
  - [8+:log2(FIFO_DEPTH)+1] fifo count
  - remaining bits 0
- FSM states and transitions:
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into the shift register, baud counter=0, go START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go DATA, bit index=0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit; shift right after each bit. After bit 7 go STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1; the state/bit advances on the cycle the counter equals CLKS_PER_BIT-1, and the counter wraps to 0.
- Latency:
  - Store at edge E (FIFO empty, IDLE) → pop at edge E+1 → tx falls after edge E+1.
  - Start bit occupies edges E+1..E+1+CLKS_PER_BIT.
- Back-to-back frames: IDLE lasts exactly one cycle between frames, so the frame period is 10*CLKS_PER_BIT+1 cycles.
- tx is driven from a flop (no glitches). tx_busy=1 in START/DATA/STOP.
- A push into an empty FIFO is not bypassed; the byte is popped on the following edge.
- Pointer wrap: pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits; full when count==FIFO_DEPTH.

Decomposition:
- Shared package uart_pkg:
  - tx state enum (IDLE, START, DATA, STOP)
  - status bit index constants (STAT_FULL=0, STAT_EMPTY=1, STAT_OVF=2, STAT_BUSY=3, STAT_CNT_LSB=8)
  - default TX_ADDR/STAT_ADDR and CLKS_PER_BIT constants, shared later with the RX block
- One sub-module, sync_fifo (parameters WIDTH=8, DEPTH):
  - ports clk, reset, push, pop, din, dout, full, empty, count
  - reused for the future RX path
- The FSM, baud counter, address decode and status mux live in uart_tx_mmio.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4 unless noted):
- Reset: assert reset mid-frame → tx=1, tx_busy=0 and status=32'h0000_0002 immediately; the held-off frame never resumes.
- Single byte: store 0xA5 to 0x400 at edge E → tx low for E+1..E+5, then bits 1,0,1,0,0,1,0,1 (4 cycles each), stop high for 4 cycles, tx_busy falls at E+41.
- Back-to-back: store 0x55 then 0x0F on consecutive cycles → two frames with a 1-cycle idle gap, period 41 cycles; sampled bytes match in order.
- Full/overflow:
  - Store 6 bytes in 6 consecutive cycles → first byte popped at the 2nd edge.
  - FIFO reaches count 4 with full=1; the 6th store is dropped and status[2]=1.
  - Only 5 bytes are transmitted.
  - Store 32'h4 to 0x404 → overflow clears.
- Push on a full FIFO coincident with a pop (IDLE with the FIFO full) → byte accepted, count stays 4, no overflow.
- Address decode:
  - Stores to 0x408 and 0x3FC → no FIFO change, tx stays 1.
  - Reading with address=0x400 → read_data=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: serialiser states, status-word bit positions and
// default memory map / timing constants used by the TX (and later RX) blocks.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int unsigned STAT_FULL    = 0;
  localparam int unsigned STAT_EMPTY   = 1;
  localparam int unsigned STAT_OVF     = 2;
  localparam int unsigned STAT_BUSY    = 3;
  localparam int unsigned STAT_CNT_LSB = 8;

  localparam logic [31:0] UART_TX_ADDR      = 32'h0000_0400;
  localparam logic [31:0] UART_STAT_ADDR    = 32'h0000_0404;
  localparam int          UART_CLKS_PER_BIT = 434;
  localparam int          UART_FIFO_DEPTH   = 8;

endpackage

// File: rtl/uart_tx_mmio_if.sv
// CPU store/load side plus serial outputs of the memory-mapped UART transmitter.
interface uart_tx_mmio_if;
  logic        mem_write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        tx;
  logic        tx_busy;

  modport master (
    output mem_write, address, write_data,
    input  read_data, tx, tx_busy
  );

  modport slave (
    input  mem_write, address, write_data,
    output read_data, tx, tx_busy
  );
endinterface

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Synchronous FIFO with combinational head output; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Qualify requests against occupancy.
  always_comb begin
    w_do_pop  = pop && (r_count != '0);
    w_do_push = push && ((r_count != FULL_CNT) || w_do_pop);
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = (r_count == FULL_CNT);
  assign empty = (r_count == '0);
  assign count = r_count;
endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: CPU stores fill a byte FIFO, a baud-timed
// serialiser shifts bytes out LSB first, and a status word is readable by loads.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int          CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int          FIFO_DEPTH   = UART_FIFO_DEPTH,
  parameter logic [31:0] TX_ADDR      = UART_TX_ADDR,
  parameter logic [31:0] STAT_ADDR    = UART_STAT_ADDR
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_mmio_if.slave bus
);
  localparam int          BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam int          FCW       = $clog2(FIFO_DEPTH) + 1;

  tx_state_t      r_state;
  tx_state_t      w_state_nxt;
  logic [BW-1:0]  r_baud;
  logic [BW-1:0]  w_baud_nxt;
  logic [2:0]     r_bit;
  logic [2:0]     w_bit_nxt;
  logic [7:0]     r_shift;
  logic [7:0]     w_shift_nxt;
  logic           r_tx;
  logic           w_tx_nxt;
  logic           r_ovf;

  logic           w_push_req;
  logic           w_clr_req;
  logic           w_ovf_set;
  logic           w_pop;
  logic [7:0]     w_dout;
  logic           w_full;
  logic           w_empty;
  logic [FCW-1:0] w_count;
  logic [31:0]    w_status;
  logic           w_unused;

  assign w_push_req = bus.mem_write && (bus.address == TX_ADDR);
  assign w_clr_req  = bus.mem_write && (bus.address == STAT_ADDR) && bus.write_data[2];
  assign w_ovf_set  = w_push_req && w_full && !w_pop;
  assign w_unused   = ^bus.write_data[31:8];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push_req),
    .pop   (w_pop),
    .din   (bus.write_data[7:0]),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // Serialiser next state; tx is computed for the next cycle so it leaves a flop.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_tx_nxt    = 1'b1;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_dout;
          w_baud_nxt  = '0;
          w_state_nxt = START;
          w_tx_nxt    = 1'b0;
        end else begin
          w_tx_nxt    = 1'b1;
        end
      end
      START: begin
        w_tx_nxt = 1'b0;
        if (r_baud == BAUD_LAST) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = 3'd0;
          w_state_nxt = DATA;
          w_tx_nxt    = r_shift[0];
        end else begin
          w_baud_nxt  = r_baud + 1'b1;
        end
      end
      DATA: begin
        w_tx_nxt = r_shift[0];
        if (r_baud == BAUD_LAST) begin
          w_baud_nxt = '0;
          if (r_bit == 3'd7) begin
            w_state_nxt = STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_bit_nxt   = r_bit + 3'd1;
            w_tx_nxt    = r_shift[1];
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      STOP: begin
        w_tx_nxt = 1'b1;
        if (r_baud == BAUD_LAST) begin
          w_baud_nxt  = '0;
          w_state_nxt = IDLE;
        end else begin
          w_baud_nxt  = r_baud + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_baud_nxt  = '0;
        w_bit_nxt   = 3'd0;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  // Serialiser registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  // Sticky overflow: set by a dropped store, cleared by software.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end else if (w_clr_req) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= r_ovf;
    end
  end

  // Status word assembly.
  always_comb begin
    w_status                          = 32'h0000_0000;
    w_status[STAT_FULL]               = w_full;
    w_status[STAT_EMPTY]              = w_empty;
    w_status[STAT_OVF]                = r_ovf;
    w_status[STAT_BUSY]               = (r_state != IDLE);
    w_status[STAT_CNT_LSB +: FCW]     = w_count;
  end

  assign bus.read_data = (bus.address == STAT_ADDR) ? w_status : 32'h0000_0000;
  assign bus.tx        = r_tx;
  assign bus.tx_busy   = (r_state != IDLE);
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Randomised scoreboard bench for uart_tx_mmio (CLKS_PER_BIT=4, FIFO_DEPTH=4)
// against a timeline-level model of the FIFO, frames and status word.
module tb_uart_tx_mmio;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam int          FRAME = 10 * CPB;
  localparam logic [31:0] TXA   = 32'h0000_0400;
  localparam logic [31:0] STA   = 32'h0000_0404;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  uart_tx_mmio_if bus();

  uart_tx_mmio #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .TX_ADDR      (TXA),
    .STAT_ADDR    (STA)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc      = 0;
  int         last_edge = 0;
  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];
  int         frame_starts[$];
  logic       m_ovf      = 1'b0;
  logic       have_frame = 1'b0;
  int         cur_pop    = 0;
  logic [7:0] cur_byte   = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic m_busy(input int k);
    return have_frame && (k >= cur_pop) && (k < cur_pop + FRAME);
  endfunction

  // Expected line level after edge k, from the start edge of the current frame.
  function automatic logic exp_tx(input int k);
    int o;
    if (!m_busy(k)) return 1'b1;
    o = k - cur_pop;
    if (o < CPB) return 1'b0;
    if (o < 9 * CPB) return cur_byte[(o - CPB) / CPB];
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s        = 32'h0;
    s[0]     = (model_q.size() == DEPTH);
    s[1]     = (model_q.size() == 0);
    s[2]     = m_ovf;
    s[3]     = m_busy(cyc);
    s[10:8]  = 3'(model_q.size());
    return s;
  endfunction

  // Reference model: one step per clock edge, then line/busy comparison.
  initial begin : model
    logic        mw;
    logic [31:0] a;
    logic [31:0] d;
    forever begin
      @(posedge clk);
      cyc++;
      mw = bus.mem_write;
      a  = bus.address;
      d  = bus.write_data;
      if (reset) begin
        model_q.delete();
        exp_q.delete();
        m_ovf      = 1'b0;
        have_frame = 1'b0;
      end else begin
        if (model_q.size() > 0 && !(have_frame && cyc <= cur_pop + FRAME)) begin
          cur_byte   = model_q.pop_front();
          cur_pop    = cyc;
          have_frame = 1'b1;
          exp_q.push_back(cur_byte);
        end
        if (mw && a == TXA) begin
          if (model_q.size() < DEPTH) model_q.push_back(d[7:0]);
          else m_ovf = 1'b1;
        end else if (mw && a == STA && d[2]) begin
          m_ovf = 1'b0;
        end
      end
      #1;
      if (!reset) begin
        chk("tx_line", {31'h0, bus.tx}, {31'h0, exp_tx(cyc)});
        chk("tx_busy", {31'h0, bus.tx_busy}, {31'h0, m_busy(cyc)});
      end
    end
  end

  // Monitor: decode each frame mid-bit and score it against the expected queue.
  initial begin : monitor
    logic [7:0] b;
    logic       ok;
    logic       stop_v;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!reset && bus.tx == 1'b0) begin
        frame_starts.push_back(cyc);
        b      = 8'h00;
        ok     = 1'b1;
        stop_v = 1'b0;
        for (int t = 1; t <= 9 * CPB + CPB / 2; t++) begin
          @(negedge clk);
          if (reset) begin
            ok = 1'b0;
            break;
          end
          if (t >= CPB + CPB / 2 && t < 9 * CPB && (t % CPB) == CPB / 2)
            b[(t - CPB) / CPB] = bus.tx;
          if (t == 9 * CPB + CPB / 2) stop_v = bus.tx;
        end
        if (ok) begin
          chk("stop_bit", {31'h0, stop_v}, 32'h1);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL frame_unexpected: got byte 0x%02h, expected no frame", b);
          end else begin
            e = exp_q.pop_front();
            chk("frame_byte", {24'h0, b}, {24'h0, e});
          end
        end
      end
    end
  end

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.mem_write  = 1'b1;
    bus.address    = a;
    bus.write_data = d;
    @(posedge clk);
    #1;
    last_edge     = cyc;
    bus.mem_write = 1'b0;
  endtask

  task automatic read_status(input string name);
    @(negedge clk);
    bus.mem_write = 1'b0;
    bus.address   = STA;
    #1;
    chk(name, bus.read_data, m_status());
  endtask

  task automatic wait_idle(input int max_cyc);
    int i;
    for (i = 0; i < max_cyc; i++) begin
      @(posedge clk);
      #2;
      if (model_q.size() == 0 && exp_q.size() == 0 && !m_busy(cyc)) break;
    end
    chk("drain_in_time", {31'h0, (i < max_cyc)}, 32'h1);
  endtask

  initial begin : watchdog
    #400000;
    n_errors++;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin : stim
    int          e0;
    int          fall_at;
    int          tgt;
    int          n;
    logic        rise_seen;
    logic [31:0] rd;
    logic [31:0] addr;
    int          sel;

    bus.mem_write  = 1'b0;
    bus.address    = STA;
    bus.write_data = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx", {31'h0, bus.tx}, 32'h1);
    chk("reset_busy", {31'h0, bus.tx_busy}, 32'h0);
    chk("reset_status", bus.read_data, 32'h0000_0002);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Single byte with exact frame timing.
    frame_starts.delete();
    store(TXA, 32'h0000_00A5);
    e0        = last_edge;
    rise_seen = 1'b0;
    fall_at   = -1;
    for (int i = 0; i < 80 && fall_at < 0; i++) begin
      @(posedge clk);
      #2;
      if (bus.tx_busy) rise_seen = 1'b1;
      else if (rise_seen) fall_at = cyc;
    end
    chk("single_busy_fall", fall_at, e0 + 41);
    chk("single_frames", frame_starts.size(), 1);
    if (frame_starts.size() > 0) chk("single_start", frame_starts[0], e0 + 1);
    wait_idle(100);

    // Back-to-back stores.
    frame_starts.delete();
    store(TXA, 32'h0000_0055);
    store(TXA, 32'h0000_000F);
    wait_idle(200);
    chk("b2b_frames", frame_starts.size(), 2);
    if (frame_starts.size() == 2) chk("b2b_period", frame_starts[1] - frame_starts[0], 41);

    // Overflow: six consecutive stores into a 4-entry FIFO.
    frame_starts.delete();
    for (int i = 0; i < 6; i++) begin
      store(TXA, $urandom);
      if (i == 0) e0 = last_edge;
    end
    read_status("ovf_status");
    rd = bus.read_data;
    chk("ovf_count", {29'h0, rd[10:8]}, 32'd4);
    chk("ovf_full", {31'h0, rd[0]}, 32'h1);
    chk("ovf_flag", {31'h0, rd[2]}, 32'h1);
    store(STA, 32'h0000_0004);
    read_status("ovf_clr_status");
    chk("ovf_cleared", {31'h0, bus.read_data[2]}, 32'h0);
    wait_idle(400);
    chk("ovf_frames", frame_starts.size(), 5);
    if (frame_starts.size() > 0) chk("ovf_first_pop", frame_starts[0], e0 + 1);

    // Push into a full FIFO on the same edge as the pop.
    for (int i = 0; i < 5; i++) store(TXA, $urandom);
    read_status("full_status");
    tgt = cur_pop + FRAME + 1;
    for (int g = 0; g < 200 && cyc < tgt - 1; g++) begin
      @(posedge clk);
      #2;
    end
    store(TXA, $urandom);
    chk("full_pop_edge", last_edge, tgt);
    read_status("full_pop_status");
    rd = bus.read_data;
    chk("full_pop_count", {29'h0, rd[10:8]}, 32'd4);
    chk("full_pop_ovf", {31'h0, rd[2]}, 32'h0);
    wait_idle(600);

    // Address decode.
    frame_starts.delete();
    store(32'h0000_0408, 32'h0000_00FF);
    store(32'h0000_03FC, $urandom);
    read_status("decode_status");
    chk("decode_count", {29'h0, bus.read_data[10:8]}, 32'd0);
    @(negedge clk);
    bus.address = TXA;
    #1;
    chk("read_tx_addr", bus.read_data, 32'h0);
    repeat (20) @(posedge clk);
    #1;
    chk("decode_no_frame", frame_starts.size(), 0);

    // Randomised traffic.
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 30)) @(negedge clk);
      sel  = $urandom_range(0, 5);
      addr = (sel < 4) ? TXA : ((sel == 4) ? STA : 32'h0000_0408);
      store(addr, $urandom);
      if ($urandom_range(0, 2) == 0) read_status("rand_status");
    end
    wait_idle(1500);

    // Reset in the middle of a frame.
    store(TXA, 32'h0000_003C);
    repeat (15) @(posedge clk);
    @(negedge clk);
    bus.address = STA;
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_tx", {31'h0, bus.tx}, 32'h1);
    chk("midrst_busy", {31'h0, bus.tx_busy}, 32'h0);
    chk("midrst_status", bus.read_data, 32'h0000_0002);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n = frame_starts.size();
    repeat (60) @(posedge clk);
    #1;
    chk("midrst_no_resume", frame_starts.size(), n);
    chk("midrst_tx_idle", {31'h0, bus.tx}, 32'h1);
    read_status("midrst_status_after");

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
